// File: rtl/param_commit_scheduler_pkg.sv
// Shared constants, defaults, FSM encoding and queue entry type for the
// parameter commit scheduler.
package param_pkg;

  localparam int unsigned NUM_PARAMS   = 8;
  localparam int unsigned FIFO_DEPTH   = 8;
  localparam int unsigned MAX_PER_STEP = 4;
  localparam int unsigned ADDR_W       = 3;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W        = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CMT_W        = $clog2(MAX_PER_STEP + 1);

  localparam int unsigned LTP_IDX     = 0;
  localparam int unsigned LTD_IDX     = 1;
  localparam int unsigned P_DELTA_IDX = 2;
  localparam int unsigned CLK_DIV_IDX = 3;

  localparam logic [DATA_W-1:0] PARAM_DEFAULT [NUM_PARAMS] = '{
    32'd0, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_COMMIT = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/param_commit_scheduler_if.sv
// Host write channel into the parameter commit queue.
interface param_commit_scheduler_if;
  import param_pkg::*;

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/param_commit_scheduler_fifo.sv
// Synchronous write queue with registered full/empty flags and occupancy.
module param_fifo
  import param_pkg::*;
(
  input  logic             clk,
  input  logic             reset_global,
  input  logic             push,
  input  wr_entry_t        push_data,
  input  logic             pop,
  output wr_entry_t        pop_data_c,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  wr_entry_t        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_full;
  logic             r_empty;

  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] w_count_nxt;

  assign w_push      = push && !r_full;
  assign w_pop       = pop && !r_empty;
  assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset_global) begin
    if (reset_global) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(FIFO_DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  assign pop_data_c = r_mem[r_rd_ptr];
  assign full       = r_full;
  assign empty      = r_empty;
  assign count      = r_count;

endmodule

// File: rtl/param_commit_scheduler.sv
// Queues host parameter writes and commits them to the live bank only at
// sim_tick boundaries. Optional readback port under PARAM_READBACK_EN.
module param_commit_scheduler
  import param_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset_global,
  input  logic                         sim_tick,
  param_commit_scheduler_if.slave      wr,
  output logic [NUM_PARAMS*DATA_W-1:0] params,
  output logic                         commit_pulse,
  output logic [CNT_W-1:0]             pending,
  output logic                         overflow
`ifdef PARAM_READBACK_EN
  ,
  input  logic [ADDR_W-1:0]            rd_addr,
  output logic [DATA_W-1:0]            rd_data
`endif
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CMT_W-1:0] r_cnt;
  logic             r_commit_pulse;
  logic             r_overflow;

  logic             w_deq;
  logic             w_pulse_nxt;
  logic             w_full;
  logic             w_empty;
  logic             w_enq;
  logic [CNT_W-1:0] w_count;
  wr_entry_t        w_push_entry;
  wr_entry_t        w_head;
  logic [DATA_W-1:0] w_param_arr [NUM_PARAMS];

  assign w_push_entry = '{addr: wr.wr_addr, data: wr.wr_data};
  assign w_enq        = wr.wr_valid && !w_full;
  assign wr.wr_ready  = !w_full;

  param_fifo u_fifo (
    .clk          (clk),
    .reset_global (reset_global),
    .push         (wr.wr_valid),
    .push_data    (w_push_entry),
    .pop          (w_deq),
    .pop_data_c   (w_head),
    .full         (w_full),
    .empty        (w_empty),
    .count        (w_count)
  );

  always_ff @(posedge clk or posedge reset_global) begin
    if (reset_global) r_state <= ST_IDLE;
    else              r_state <= w_state_nxt;
  end

  // Leave COMMIT on the quota-th pop or when the pop drains the queue.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_count != '0) w_state_nxt = ST_ARMED;
      ST_ARMED:  if (sim_tick)      w_state_nxt = ST_COMMIT;
      ST_COMMIT: begin
        if (w_empty || (r_cnt == CMT_W'(MAX_PER_STEP - 1)) ||
            ((w_count == CNT_W'(1)) && !w_enq))
          w_state_nxt = ST_DONE;
      end
      ST_DONE:   w_state_nxt = (w_count != '0) ? ST_ARMED : ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_deq       = 1'b0;
    w_pulse_nxt = 1'b0;
    case (r_state)
      ST_COMMIT: w_deq       = !w_empty;
      ST_DONE:   w_pulse_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset_global) begin
    if (reset_global) begin
      r_cnt          <= '0;
      r_commit_pulse <= 1'b0;
      r_overflow     <= 1'b0;
    end else begin
      if (r_state != ST_COMMIT) r_cnt <= '0;
      else if (w_deq)           r_cnt <= r_cnt + CMT_W'(1);
      r_commit_pulse <= w_pulse_nxt;
      if (wr.wr_valid && w_full) r_overflow <= 1'b1;
    end
  end

  // The clock divider register is excluded from reset so gen_clk keeps running.
  for (genvar i = 0; i < NUM_PARAMS; i++) begin : g_param
    if (i == CLK_DIV_IDX) begin : g_noreset
      logic [DATA_W-1:0] r_val = PARAM_DEFAULT[i];
      always_ff @(posedge clk) begin
        if (w_deq && (w_head.addr == ADDR_W'(i))) r_val <= w_head.data;
      end
      assign w_param_arr[i] = r_val;
    end else begin : g_reset
      logic [DATA_W-1:0] r_val;
      always_ff @(posedge clk or posedge reset_global) begin
        if (reset_global)                              r_val <= PARAM_DEFAULT[i];
        else if (w_deq && (w_head.addr == ADDR_W'(i))) r_val <= w_head.data;
      end
      assign w_param_arr[i] = r_val;
    end
    assign params[i*DATA_W +: DATA_W] = w_param_arr[i];
  end

`ifdef PARAM_READBACK_EN
  logic [DATA_W-1:0] r_rd_data;
  always_ff @(posedge clk or posedge reset_global) begin
    if (reset_global)                     r_rd_data <= '0;
    else if (32'(rd_addr) < NUM_PARAMS)   r_rd_data <= w_param_arr[rd_addr];
    else                                  r_rd_data <= '0;
  end
  assign rd_data = r_rd_data;
`endif

  assign commit_pulse = r_commit_pulse;
  assign pending      = w_count;
  assign overflow     = r_overflow;

endmodule
